// File: rtl/arb_pkg.sv
// Shared definitions for the peripheral arbiter slice.
// Contents:
//   DATA_W      width of one requester data nibble and of the peripheral data bus
//   CNT_W       width of the completed-transfer counter
//   arb_state_e handshake FSM states of the arbiter
package arb_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENVIA    = 2'd1,
        CONFIRMA = 2'd2,
        LIBERA   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_seletor.sv
// Combinational round-robin selector.
// Picks the first set request bit at or after the pointer, wrapping mod N.
// Ports:
//   req    in   N         request vector
//   ptr    in   clog2(N)  highest-priority position for this pick
//   grant  out  N         one-hot winner (0 when no request)
//   valid  out  1         at least one request present
module rr_seletor #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic                 valid
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] pos_s;
    logic             hit_s;

    // Walk positions ptr, ptr+1, ... and keep only the first requesting one
    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s        = PTR_W'((int'(ptr) + k) % N);
            hit_s        = req[pos_s] & ~valid;
            grant[pos_s] = hit_s;
            valid        = valid | hit_s;
        end
    end

endmodule

// File: rtl/arbitro_periferico.sv
// Round-robin arbiter sharing one PERIFERICO data port among N CPU requesters.
// Both sides use the send/ack four-phase handshake; the granted requester's
// data nibble is latched at grant time and held until the transfer ends.
// Ports:
//   arb_clock     in   1        clock, rising edge
//   arb_reset     in   1        asynchronous active-low reset
//   arb_send      in   N        per-requester send
//   arb_dados     in   4*N      requester i data at [4i+3:4i]
//   arb_ack       out  N        one-hot ack to the granted requester
//   arb_grant     out  N        one-hot current grant, 0 when idle
//   arb_busy      out  1        high whenever the FSM is not in IDLE
//   arb_erro      out  1        one-cycle pulse on timeout or requester abort
//   arb_contador  out  8        completed transfers, wraps 255 -> 0
//   per_send      out  1        send to peripheral
//   per_dados     out  4        data to peripheral
//   per_ack       in   1        ack from peripheral
module arbitro_periferico
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  arb_clock,
    input  logic                  arb_reset,
    input  logic [N-1:0]          arb_send,
    input  logic [DATA_W*N-1:0]   arb_dados,
    output logic [N-1:0]          arb_ack,
    output logic [N-1:0]          arb_grant,
    output logic                  arb_busy,
    output logic                  arb_erro,
    output logic [CNT_W-1:0]      arb_contador,
    output logic                  per_send,
    output logic [DATA_W-1:0]     per_dados,
    input  logic                  per_ack
);

    localparam int PTR_W = $clog2(N);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    // Counter value seen on the TIMEOUT-th consecutive ENVIA cycle
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

    arb_state_e        state_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [PTR_W-1:0]  idx_r;
    logic [TMO_W-1:0]  tmo_r;

    logic [N-1:0]      sel_grant_s;
    logic              sel_valid_s;
    logic [PTR_W-1:0]  sel_idx_s;
    logic [DATA_W-1:0] sel_dados_s;
    logic              granted_send_s;

    rr_seletor #(
        .N(N)
    ) u_rr_seletor (
        .req   (arb_send),
        .ptr   (ptr_r),
        .grant (sel_grant_s),
        .valid (sel_valid_s)
    );

    // One-hot winner to index and data nibble; AND-OR is safe because the grant is one-hot
    always_comb begin
        sel_idx_s   = '0;
        sel_dados_s = '0;
        for (int k = 0; k < N; k++) begin
            sel_idx_s   = sel_idx_s | (PTR_W'(k) & {PTR_W{sel_grant_s[k]}});
            sel_dados_s = sel_dados_s |
                          (arb_dados[k*DATA_W +: DATA_W] & {DATA_W{sel_grant_s[k]}});
        end
        granted_send_s = |(arb_send & arb_grant);
    end

    // Handshake FSM with registered outputs, timeout counter and transfer counter
    always_ff @(posedge arb_clock or negedge arb_reset) begin
        if (!arb_reset) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            idx_r        <= '0;
            tmo_r        <= '0;
            arb_ack      <= '0;
            arb_grant    <= '0;
            arb_busy     <= 1'b0;
            arb_erro     <= 1'b0;
            arb_contador <= '0;
            per_send     <= 1'b0;
            per_dados    <= '0;
        end else begin
            arb_erro <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sel_valid_s) begin
                        arb_grant <= sel_grant_s;
                        idx_r     <= sel_idx_s;
                        per_dados <= sel_dados_s;
                        per_send  <= 1'b1;
                        arb_busy  <= 1'b1;
                        tmo_r     <= '0;
                        state_r   <= ENVIA;
                    end
                end
                ENVIA: begin
                    // Ack wins over abort, abort wins over timeout
                    if (per_ack) begin
                        arb_ack <= arb_grant;
                        state_r <= CONFIRMA;
                    end else if (!granted_send_s) begin
                        per_send <= 1'b0;
                        arb_erro <= 1'b1;
                        state_r  <= LIBERA;
                    end else if (tmo_r == TMO_LAST) begin
                        per_send <= 1'b0;
                        arb_erro <= 1'b1;
                        state_r  <= LIBERA;
                    end else begin
                        tmo_r <= tmo_r + 1'b1;
                    end
                end
                CONFIRMA: begin
                    if (!granted_send_s) begin
                        per_send     <= 1'b0;
                        arb_ack      <= '0;
                        arb_contador <= arb_contador + 1'b1;
                        state_r      <= LIBERA;
                    end
                end
                LIBERA: begin
                    // Pointer moves past the served requester whatever the outcome was
                    if (!per_ack) begin
                        ptr_r     <= (idx_r == PTR_LAST) ? '0 : idx_r + 1'b1;
                        arb_grant <= '0;
                        per_dados <= '0;
                        arb_busy  <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_periferico.sv
module tb_arbitro_periferico;

    localparam int N       = 4;
    localparam int TIMEOUT = 15;
    localparam int M_DONE  = 0;
    localparam int M_ABORT = 1;
    localparam int M_TMO   = 2;

    logic             arb_clock = 1'b0;
    logic             arb_reset;
    logic [N-1:0]     arb_send;
    logic [4*N-1:0]   arb_dados;
    logic [N-1:0]     arb_ack;
    logic [N-1:0]     arb_grant;
    logic             arb_busy;
    logic             arb_erro;
    logic [7:0]       arb_contador;
    logic             per_send;
    logic [3:0]       per_dados;
    logic             per_ack;

    arbitro_periferico #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .arb_clock    (arb_clock),
        .arb_reset    (arb_reset),
        .arb_send     (arb_send),
        .arb_dados    (arb_dados),
        .arb_ack      (arb_ack),
        .arb_grant    (arb_grant),
        .arb_busy     (arb_busy),
        .arb_erro     (arb_erro),
        .arb_contador (arb_contador),
        .per_send     (per_send),
        .per_dados    (per_dados),
        .per_ack      (per_ack)
    );

    always #5 arb_clock = ~arb_clock;

    typedef struct {
        logic [N-1:0] req;
        logic [15:0]  dados;
        int           mode;
        int           dly;
        int           exp_idx;
        logic [3:0]   exp_d;
    } vec_t;

    vec_t tbl [11];

    int n_vec  = 0;
    int n_err  = 0;
    int ptr_m  = 0;   // reference pointer
    int cnt_m  = 0;   // reference completed-transfer count mod 256
    int done_m = 0;   // completed transfers in the random phase

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge arb_clock);
        #1;
    endtask

    // Reference round-robin: first requesting position at or after ptr, mod N
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (((req >> ((ptr + k) % N)) & 4'd1) != 4'd0) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_idle;
        chk("idle_grant", 32'(arb_grant), 32'd0);
        chk("idle_busy",  32'(arb_busy),  32'd0);
        chk("idle_send",  32'(per_send),  32'd0);
        chk("idle_dados", 32'(per_dados), 32'd0);
        chk("idle_erro",  32'(arb_erro),  32'd0);
        chk("idle_cnt",   32'(arb_contador), 32'(cnt_m));
    endtask

    // Plays both requesters and the peripheral for one transfer and checks it
    task automatic run_xfer(input logic [N-1:0] req, input logic [15:0] dados, input int mode,
                            input int dly, input int exp_idx, input logic [3:0] exp_d);
        logic [N-1:0] onehot;
        onehot    = 4'b0001 << exp_idx;
        arb_send  = req;
        arb_dados = dados;
        per_ack   = 1'b0;
        tick;
        chk("grant",     32'(arb_grant), 32'(onehot));
        chk("per_send",  32'(per_send),  32'd1);
        chk("per_dados", 32'(per_dados), 32'(exp_d));
        chk("busy",      32'(arb_busy),  32'd1);
        arb_dados = ~dados;
        if (mode == M_TMO) begin
            for (int c = 1; c < TIMEOUT; c++) begin
                tick;
                chk("tmo_wait_send", 32'(per_send), 32'd1);
            end
            chk("tmo_wait_erro", 32'(arb_erro), 32'd0);
            chk("latch_dados",   32'(per_dados), 32'(exp_d));
            tick;
            chk("tmo_send", 32'(per_send), 32'd0);
            chk("tmo_erro", 32'(arb_erro), 32'd1);
            chk("tmo_ack",  32'(arb_ack),  32'd0);
            tick;
        end else if (mode == M_ABORT) begin
            for (int c = 0; c < dly; c++) begin
                tick;
                chk("abort_wait_dados", 32'(per_dados), 32'(exp_d));
            end
            arb_send = req & ~onehot;
            tick;
            chk("abort_send",  32'(per_send),  32'd0);
            chk("abort_erro",  32'(arb_erro),  32'd1);
            chk("abort_ack",   32'(arb_ack),   32'd0);
            chk("abort_grant", 32'(arb_grant), 32'(onehot));
            per_ack = 1'b1;
            tick;
            chk("libera_hold_busy", 32'(arb_busy), 32'd1);
            chk("libera_erro_once", 32'(arb_erro), 32'd0);
            per_ack = 1'b0;
            tick;
        end else begin
            for (int c = 0; c < dly; c++) begin
                tick;
                chk("wait_send",  32'(per_send),  32'd1);
                chk("wait_dados", 32'(per_dados), 32'(exp_d));
            end
            per_ack = 1'b1;
            tick;
            chk("ack",       32'(arb_ack),      32'(onehot));
            chk("ack_cnt",   32'(arb_contador), 32'(cnt_m));
            arb_send = req & ~onehot;
            tick;
            cnt_m = (cnt_m + 1) % 256;
            chk("done_send", 32'(per_send),     32'd0);
            chk("done_ack",  32'(arb_ack),      32'd0);
            chk("done_cnt",  32'(arb_contador), 32'(cnt_m));
            chk("done_erro", 32'(arb_erro),     32'd0);
            if (dly % 2 == 1) begin
                tick;
                chk("libera_wait_busy", 32'(arb_busy), 32'd1);
            end
            per_ack = 1'b0;
            tick;
        end
        chk_idle;
        ptr_m = (exp_idx + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] rq;
        logic [15:0]  dd;
        int           md;
        int           dl;
        int           ix;
        int           iter;

        tbl[0]  = '{4'b1111, 16'h4321, M_DONE,  0, 0, 4'h1};
        tbl[1]  = '{4'b1111, 16'h4321, M_DONE,  1, 1, 4'h2};
        tbl[2]  = '{4'b1111, 16'h4321, M_DONE,  0, 2, 4'h3};
        tbl[3]  = '{4'b1111, 16'h4321, M_DONE,  2, 3, 4'h4};
        tbl[4]  = '{4'b1111, 16'h4321, M_DONE,  0, 0, 4'h1};
        tbl[5]  = '{4'b0010, 16'h00B0, M_TMO,   0, 1, 4'hB};
        tbl[6]  = '{4'b0110, 16'h0CD0, M_DONE,  0, 2, 4'hC};
        tbl[7]  = '{4'b0001, 16'h0005, M_ABORT, 2, 0, 4'h5};
        tbl[8]  = '{4'b1001, 16'h7008, M_DONE,  3, 3, 4'h7};
        tbl[9]  = '{4'b0100, 16'h0A00, M_DONE,  0, 2, 4'hA};
        tbl[10] = '{4'b0101, 16'h0906, M_DONE,  1, 0, 4'h6};

        arb_reset = 1'b0;
        arb_send  = '0;
        arb_dados = '0;
        per_ack   = 1'b0;
        repeat (2) @(posedge arb_clock);
        #1;
        chk("rst_ack",   32'(arb_ack),      32'd0);
        chk("rst_grant", 32'(arb_grant),    32'd0);
        chk("rst_busy",  32'(arb_busy),     32'd0);
        chk("rst_erro",  32'(arb_erro),     32'd0);
        chk("rst_cnt",   32'(arb_contador), 32'd0);
        chk("rst_send",  32'(per_send),     32'd0);
        chk("rst_dados", 32'(per_dados),    32'd0);
        arb_reset = 1'b1;
        tick;

        for (int v = 0; v < 11; v++) begin
            run_xfer(tbl[v].req, tbl[v].dados, tbl[v].mode, tbl[v].dly,
                     tbl[v].exp_idx, tbl[v].exp_d);
        end

        // Idle with no requests must stay idle
        arb_send = '0;
        tick;
        tick;
        chk_idle;

        // Reset in CONFIRMA clears outputs without a clock edge
        arb_send  = 4'b0100;
        arb_dados = 16'h0E00;
        tick;
        per_ack = 1'b1;
        tick;
        chk("pre_rst_ack", 32'(arb_ack), 32'h4);
        #2;
        arb_reset = 1'b0;
        #1;
        chk("async_ack",   32'(arb_ack),      32'd0);
        chk("async_grant", 32'(arb_grant),    32'd0);
        chk("async_busy",  32'(arb_busy),     32'd0);
        chk("async_send",  32'(per_send),     32'd0);
        chk("async_dados", 32'(per_dados),    32'd0);
        chk("async_cnt",   32'(arb_contador), 32'd0);
        per_ack  = 1'b0;
        arb_send = '0;
        tick;
        arb_reset = 1'b1;
        ptr_m = 0;
        cnt_m = 0;
        run_xfer(4'b1111, 16'h1234, M_DONE, 0, 0, 4'h4);
        done_m = 1;

        // Random traffic against the reference; runs past 256 completions to cover the wrap
        iter = 0;
        while (done_m < 262 && iter < 2000) begin
            rq = 4'($urandom_range(1, 15));
            dd = 16'($urandom);
            md = $urandom_range(0, 9);
            dl = $urandom_range(0, 3);
            md = (md == 0) ? M_TMO : ((md == 1) ? M_ABORT : M_DONE);
            ix = rr_pick(rq, ptr_m);
            run_xfer(rq, dd, md, dl, ix, dd[ix*4 +: 4]);
            if (md == M_DONE) done_m++;
            iter++;
        end
        chk("wrap_cnt", 32'(arb_contador), 32'(done_m % 256));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
